branch_resolve_unit: RTL and testbench

Pipelined, width-parametrised branch condition evaluator for the MIPS core, with an integrated 2-bit saturating branch predictor table.
- Accepts one branch operation per cycle: operands a and b, a 4-bit branch function, a PC-derived table index, and the fetch-stage prediction.
- Returns a registered taken/not-taken result plus a mispredict flag.
- Trains the predictor table on every resolved branch and counts mispredicts.
- Sits between the decode/execute boundary and the fetch redirect logic, behind a valid/ready handshake.

---
 rtl/branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_branch_resolve_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch condition evaluator with a 2-bit saturating predictor table and a saturating mispredict counter.
// One-cycle registered result; when the result is stalled, in_ready drops and out_* hold.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_bf,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_pred,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_is_branch,
  output logic             out_mispredict,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  output logic [CNT_W-1:0] miss_count
);

  localparam int DEPTH = 1 << IDX_W;

  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic             out_is_branch_q, out_is_branch_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [1:0]       cnt_q [DEPTH];
  logic [1:0]       cnt_d [DEPTH];

  logic sign, zero, eq, taken, is_branch, mispred, accept;

  always_comb begin
    sign      = in_a[WIDTH-1];
    zero      = (in_a == '0);
    eq        = (in_a == in_b);
    taken     = 1'b0;
    is_branch = 1'b1;
    case (in_bf)
      4'b0010:          taken = sign;
      4'b0011:          taken = ~sign;
      4'b1000, 4'b1001: taken = eq;
      4'b1010, 4'b1011: taken = ~eq;
      4'b1100, 4'b1101: taken = sign | zero;
      4'b1110, 4'b1111: taken = ~sign & ~zero;
      default:          is_branch = 1'b0;
    endcase
    mispred = is_branch & (taken != in_pred);
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_is_branch_d  = out_is_branch_q;
    out_mispredict_d = out_mispredict_q;
    miss_d           = miss_q;
    cnt_d            = cnt_q;
    if (accept) begin
      out_valid_d      = 1'b1;
      out_taken_d      = taken;
      out_is_branch_d  = is_branch;
      out_mispredict_d = mispred;
      if (mispred && !(&miss_q)) begin
        miss_d = miss_q + CNT_W'(1);
      end
      if (is_branch) begin
        if (taken) begin
          if (cnt_q[in_idx] != 2'b11) cnt_d[in_idx] = cnt_q[in_idx] + 2'd1;
        end else begin
          if (cnt_q[in_idx] != 2'b00) cnt_d[in_idx] = cnt_q[in_idx] - 2'd1;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_is_branch_q  <= 1'b0;
      out_mispredict_q <= 1'b0;
      miss_q           <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_is_branch_q  <= out_is_branch_d;
      out_mispredict_q <= out_mispredict_d;
      miss_q           <= miss_d;
      cnt_q            <= cnt_d;
    end
  end

  // Reads the registered array, so a same-cycle update is seen only from the next cycle.
  assign lookup_taken   = cnt_q[lookup_idx][1];
  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_is_branch  = out_is_branch_q;
  assign out_mispredict = out_mispredict_q;
  assign miss_count     = miss_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: a 32-bit instance (4-bit miss counter) and a 2-bit-operand instance.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, in_pred = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [3:0]  in_bf = '0, in_idx = '0, lookup_idx = '0, miss_count;
  logic        out_valid, out_ready = 1'b1, out_taken, out_is_branch, out_mispredict, lookup_taken;

  branch_resolve_unit #(.WIDTH(32), .IDX_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bf(in_bf), .in_idx(in_idx), .in_pred(in_pred),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_is_branch(out_is_branch), .out_mispredict(out_mispredict),
    .lookup_idx(lookup_idx), .lookup_taken(lookup_taken), .miss_count(miss_count)
  );

  logic       w_in_valid = 1'b0, w_in_ready, w_in_pred = 1'b0;
  logic [1:0] w_in_a = '0, w_in_b = '0, w_in_idx = '0, w_lookup_idx = '0;
  logic [3:0] w_in_bf = '0, w_miss_count;
  logic       w_out_valid, w_out_taken, w_out_is_branch, w_out_mispredict, w_lookup_taken;

  branch_resolve_unit #(.WIDTH(2), .IDX_W(2), .CNT_W(4)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_bf(w_in_bf), .in_idx(w_in_idx), .in_pred(w_in_pred),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_taken(w_out_taken),
    .out_is_branch(w_out_is_branch), .out_mispredict(w_out_mispredict),
    .lookup_idx(w_lookup_idx), .lookup_taken(w_lookup_taken), .miss_count(w_miss_count)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted operation; returns #1 after the loading edge with in_valid dropped.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] bf,
                      input logic [3:0] idx, input logic pred);
    in_a = a; in_b = b; in_bf = bf; in_idx = idx; in_pred = pred;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_w2(input logic [1:0] a, input logic [3:0] bf);
    w_in_a = a; w_in_b = 2'b00; w_in_bf = bf; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_miss", miss_count, 0);
    lookup_idx = 4'd0; #1;
    chk("rst_lookup0", lookup_taken, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // eq taken against a not-taken prediction
    send(32'h1234_5678, 32'h1234_5678, 4'b1000, 4'd3, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_taken", out_taken, 1);
    chk("t1_isbr", out_is_branch, 1);
    chk("t1_misp", out_mispredict, 1);
    chk("t1_miss", miss_count, 1);
    lookup_idx = 4'd3; #1;
    chk("t1_lookup3", lookup_taken, 1);

    // sign/zero edges
    send(32'h8000_0000, 32'h0, 4'b0010, 4'd0, 1'b1);
    chk("t2_bltz_taken", out_taken, 1);
    chk("t2_bltz_misp", out_mispredict, 0);
    send(32'h0, 32'h0, 4'b1100, 4'd0, 1'b1);
    chk("t2_blez_zero", out_taken, 1);
    send(32'h0, 32'h0, 4'b1110, 4'd1, 1'b0);
    chk("t2_bgtz_zero", out_taken, 0);
    chk("t2_bgtz_misp", out_mispredict, 0);
    send(32'h0000_0001, 32'h0, 4'b0011, 4'd1, 1'b1);
    chk("t2_bgez_pos", out_taken, 1);
    send(32'h0, 32'h0, 4'b0101, 4'd3, 1'b1);
    chk("t2_nb_isbr", out_is_branch, 0);
    chk("t2_nb_taken", out_taken, 0);
    chk("t2_nb_misp", out_mispredict, 0);
    chk("t2_nb_miss", miss_count, 1);
    lookup_idx = 4'd3; #1;
    chk("t2_nb_no_update", lookup_taken, 1);
    send(32'd5, 32'd6, 4'b1010, 4'd1, 1'b0);
    chk("t2_bne_taken", out_taken, 1);
    chk("t2_bne_miss", miss_count, 2);
    send(32'd5, 32'd6, 4'b1001, 4'd8, 1'b1);
    chk("t2_beq_ne_taken", out_taken, 0);
    chk("t2_beq_ne_misp", out_mispredict, 1);
    chk("t2_beq_ne_miss", miss_count, 3);

    // predictor saturation on idx 7
    lookup_idx = 4'd7;
    for (int i = 0; i < 5; i++) send(32'd9, 32'd9, 4'b1000, 4'd7, 1'b1);
    chk("t3_sat_hi", lookup_taken, 1);
    send(32'd9, 32'd9, 4'b1010, 4'd7, 1'b0);
    chk("t3_dec1", lookup_taken, 1);
    send(32'd9, 32'd9, 4'b1010, 4'd7, 1'b0);
    chk("t3_dec2", lookup_taken, 0);
    send(32'd9, 32'd9, 4'b1010, 4'd7, 1'b0);
    chk("t3_dec3", lookup_taken, 0);
    send(32'd9, 32'd9, 4'b1000, 4'd7, 1'b1);
    chk("t3_sat_lo", lookup_taken, 0);

    // miss counter: 3 + 20 mispredicts must hold at 15
    for (int i = 0; i < 20; i++) send(32'd1, 32'd1, 4'b1000, 4'd9, 1'b0);
    chk("t3_miss_sat", miss_count, 15);

    // backpressure
    @(posedge clk); #1;
    chk("t4_drain", out_valid, 0);
    in_a = 32'd4; in_b = 32'd4; in_bf = 4'b1000; in_idx = 4'd10; in_pred = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_bf = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_ready", in_ready, 0);
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_taken", out_taken, 1);
      chk("t4_stall_isbr", out_is_branch, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("t4_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_replace_valid", out_valid, 1);
    chk("t4_replace_isbr", out_is_branch, 0);
    chk("t4_replace_taken", out_taken, 0);
    @(posedge clk); #1;
    chk("t4_empty", out_valid, 0);

    // read-before-write on idx 2
    lookup_idx = 4'd2;
    in_a = 32'd7; in_b = 32'd7; in_bf = 4'b1000; in_idx = 4'd2; in_pred = 1'b0;
    in_valid = 1'b1; #1;
    chk("t5_before", lookup_taken, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5_after", lookup_taken, 1);

    // asynchronous reset mid-stream
    send(32'd3, 32'd3, 4'b1000, 4'd5, 1'b1);
    send(32'd3, 32'd3, 4'b1000, 4'd5, 1'b1);
    lookup_idx = 4'd5; #1;
    chk("t6_pre_lookup", lookup_taken, 1);
    chk("t6_pre_valid", out_valid, 1);
    #1 rst = 1'b1; #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_taken", out_taken, 0);
    chk("t6_lookup5", lookup_taken, 0);
    chk("t6_miss", miss_count, 0);
    chk("t6_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_ready_after", in_ready, 1);
    chk("t6_valid_after", out_valid, 0);

    // WIDTH=2: bit 1 is the sign
    send_w2(2'b10, 4'b0010);
    chk("w2_bltz", w_out_taken, 1);
    send_w2(2'b01, 4'b1110);
    chk("w2_bgtz_pos", w_out_taken, 1);
    send_w2(2'b10, 4'b1110);
    chk("w2_bgtz_neg", w_out_taken, 0);
    send_w2(2'b00, 4'b1100);
    chk("w2_blez_zero", w_out_taken, 1);
    send_w2(2'b01, 4'b0011);
    chk("w2_bgez_pos", w_out_taken, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
